// File: rtl/cache_pkg.sv
// Shared types and field-width helpers for the N-way L1 cache.
package cache_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_FILL,
    S_WRITE,
    S_RESP
  } state_t;

  function automatic int index_w(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int off_w(input int words);
    return $clog2(words);
  endfunction

  function automatic int age_w(input int ways);
    return $clog2(ways);
  endfunction

  function automatic int tag_w(input int addr_w, input int sets, input int words);
    return addr_w - $clog2(sets) - $clog2(words);
  endfunction

endpackage

// File: rtl/cache_lru_nway.sv
// True-LRU age array, one age per way per set; reports the oldest way of the addressed set.
module cache_lru_nway
  import cache_pkg::*;
#(
  parameter int WAYS = 2,
  parameter int SETS = 2,
  localparam int INDEX_W = index_w(SETS),
  localparam int AGE_W = age_w(WAYS)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [INDEX_W-1:0] set,
  input  logic               touch,
  input  logic [AGE_W-1:0]   way,
  output logic [AGE_W-1:0]   victim
);

  logic [AGE_W-1:0] age [SETS][WAYS];

  // Ages stay a permutation of 0..WAYS-1, so exactly one way holds the maximum.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < SETS; s++)
        for (int w = 0; w < WAYS; w++)
          age[s][w] <= AGE_W'(w);
    end else if (touch) begin
      for (int w = 0; w < WAYS; w++) begin
        if (AGE_W'(w) == way)
          age[set][w] <= '0;
        else if (age[set][w] < age[set][way])
          age[set][w] <= age[set][w] + 1'b1;
      end
    end
  end

  always_comb begin
    victim = '0;
    for (int w = 0; w < WAYS; w++)
      if (age[set][w] == AGE_W'(WAYS - 1))
        victim = AGE_W'(w);
  end

endmodule

// File: rtl/cache_l1_nway.sv
// N-way set-associative write-through, no-write-allocate L1 cache with true-LRU replacement.
// Optional hit/miss counters are built when CACHE_STATS_EN is defined.
//   state    | meaning
//   S_IDLE   | ready, waiting for a CPU request
//   S_LOOKUP | parallel tag compare of the addressed set
//   S_FILL   | line refill from memory, one beat per ack
//   S_WRITE  | store forwarded to memory, waiting for ack
//   S_RESP   | one-cycle response to the CPU
module cache_l1_nway
  import cache_pkg::*;
#(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 16,
  parameter int WAYS   = 2,
  parameter int SETS   = 2,
  parameter int WORDS  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_wren,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ready,
  output logic              cpu_valid,
  output logic              hit,
  output logic [DATA_W-1:0] q,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]       stat_hits,
  output logic [31:0]       stat_misses
`endif
);

  localparam int INDEX_W = index_w(SETS);
  localparam int OFF_W   = off_w(WORDS);
  localparam int TAG_W   = tag_w(ADDR_W, SETS, WORDS);
  localparam int WAY_W   = age_w(WAYS);

  state_t state, state_nxt;

  logic              req_wren;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [TAG_W-1:0]  req_tag;
  logic [INDEX_W-1:0] req_idx;
  logic [OFF_W-1:0]  req_off;
  assign {req_tag, req_idx, req_off} = req_addr;

  logic [WAYS-1:0]   valid_arr [SETS];
  logic [TAG_W-1:0]  tag_arr   [SETS][WAYS];
  logic [DATA_W-1:0] data_arr  [SETS][WAYS][WORDS];

  logic              lk_hit, any_inv;
  logic [WAY_W-1:0]  lk_way, inv_way, lru_victim, victim;
  logic              hit_r, gap;
  logic [WAY_W-1:0]  way_r;
  logic [OFF_W:0]    beat;
  logic [DATA_W-1:0] q_r;
  logic              fill_ack, fill_last, lru_touch;
  logic [WAY_W-1:0]  lru_way;

  // Descending scan so the lowest-index match / invalid way wins.
  always_comb begin
    lk_hit  = 1'b0;
    lk_way  = '0;
    any_inv = 1'b0;
    inv_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_arr[req_idx][w] && tag_arr[req_idx][w] == req_tag) begin
        lk_hit = 1'b1;
        lk_way = WAY_W'(w);
      end
      if (!valid_arr[req_idx][w]) begin
        any_inv = 1'b1;
        inv_way = WAY_W'(w);
      end
    end
  end

  assign victim    = any_inv ? inv_way : lru_victim;
  assign fill_ack  = (state == S_FILL) && !gap && mem_ack;
  assign fill_last = fill_ack && (beat == (OFF_W+1)'(WORDS - 1));

  always_comb begin
    lru_touch = 1'b0;
    lru_way   = '0;
    if (state == S_LOOKUP && lk_hit) begin
      lru_touch = 1'b1;
      lru_way   = lk_way;
    end else if (fill_last) begin
      lru_touch = 1'b1;
      lru_way   = way_r;
    end
  end

  cache_lru_nway #(.WAYS(WAYS), .SETS(SETS)) u_lru (
    .clk    (clk),
    .reset  (reset),
    .set    (req_idx),
    .touch  (lru_touch),
    .way    (lru_way),
    .victim (lru_victim)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (cpu_req) state_nxt = S_LOOKUP;
      S_LOOKUP: state_nxt = req_wren ? S_WRITE : (lk_hit ? S_RESP : S_FILL);
      S_FILL:   if (fill_last) state_nxt = S_RESP;
      S_WRITE:  if (mem_ack) state_nxt = S_RESP;
      S_RESP:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    cpu_ready = (state == S_IDLE);
    cpu_valid = (state == S_RESP);
    hit       = (state == S_RESP) && hit_r;
    q         = (state == S_RESP) ? q_r : '0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (state == S_FILL) begin
      mem_req  = !gap;
      mem_addr = {req_tag, req_idx, beat[OFF_W-1:0]};
    end else if (state == S_WRITE) begin
      mem_req   = 1'b1;
      mem_we    = 1'b1;
      mem_addr  = req_addr;
      mem_wdata = req_wdata;
    end
  end

  // Valid bits are only set on the last beat, so an aborted refill leaves the way invalid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_wren  <= 1'b0;
      req_addr  <= '0;
      req_wdata <= '0;
      hit_r     <= 1'b0;
      way_r     <= '0;
      beat      <= '0;
      gap       <= 1'b0;
      q_r       <= '0;
      for (int s = 0; s < SETS; s++) valid_arr[s] <= '0;
    end else begin
      case (state)
        S_IDLE: if (cpu_req) begin
          req_wren  <= cpu_wren;
          req_addr  <= cpu_addr;
          req_wdata <= cpu_wdata;
        end
        S_LOOKUP: begin
          hit_r <= lk_hit;
          way_r <= lk_hit ? lk_way : victim;
          beat  <= '0;
          gap   <= 1'b0;
          q_r   <= lk_hit ? data_arr[req_idx][lk_way][req_off] : '0;
        end
        S_FILL: begin
          if (gap) begin
            gap <= 1'b0;
          end else if (mem_ack) begin
            beat <= beat + 1'b1;
            gap  <= 1'b1;
            if (beat[OFF_W-1:0] == req_off) q_r <= mem_rdata;
            if (fill_last) valid_arr[req_idx][way_r] <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (fill_ack) data_arr[req_idx][way_r][beat[OFF_W-1:0]] <= mem_rdata;
    if (fill_last) tag_arr[req_idx][way_r] <= req_tag;
    if (state == S_LOOKUP && req_wren && lk_hit)
      data_arr[req_idx][lk_way][req_off] <= req_wdata;
  end

`ifdef CACHE_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_hits   <= '0;
      stat_misses <= '0;
    end else if (state == S_RESP) begin
      if (hit_r) begin
        if (stat_hits != '1) stat_hits <= stat_hits + 1'b1;
      end else begin
        if (stat_misses != '1) stat_misses <= stat_misses + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_cache_l1_nway.sv
// Directed bench for cache_l1_nway with a latency-3 memory responder and hand-computed expectations.
module tb_cache_l1_nway;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_wren;
  logic [6:0]  cpu_addr;
  logic [15:0] cpu_wdata;
  logic        cpu_ready, cpu_valid, hit;
  logic [15:0] q;
  logic        mem_req, mem_we;
  logic [6:0]  mem_addr;
  logic [15:0] mem_wdata, mem_rdata;
  logic        mem_ack;
`ifdef CACHE_STATS_EN
  logic [31:0] stat_hits, stat_misses;
`endif

  always #5 clk = ~clk;

  cache_l1_nway dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_req   (cpu_req),
    .cpu_wren  (cpu_wren),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_ready (cpu_ready),
    .cpu_valid (cpu_valid),
    .hit       (hit),
    .q         (q),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack)
`ifdef CACHE_STATS_EN
    ,
    .stat_hits   (stat_hits),
    .stat_misses (stat_misses)
`endif
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  logic [15:0] mem_model [128];
  logic [6:0]  log_addr [64];
  logic        log_we   [64];
  logic [15:0] log_wd   [64];
  int          log_n = 0;
  int          gap_viol = 0;
  int          hold_viol = 0;

  // Memory side: ack after mem_req has been seen on three consecutive falling edges.
  initial begin
    int wait_cnt;
    wait_cnt  = 0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (mem_ack) begin
        mem_ack = 1'b0;
        if (mem_req) gap_viol++;
      end else if (mem_req) begin
        wait_cnt++;
        if (wait_cnt >= 3) begin
          wait_cnt  = 0;
          mem_ack   = 1'b1;
          mem_rdata = mem_model[mem_addr];
          log_addr[log_n % 64] = mem_addr;
          log_we[log_n % 64]   = mem_we;
          log_wd[log_n % 64]   = mem_wdata;
          log_n++;
          if (mem_we) mem_model[mem_addr] = mem_wdata;
        end
      end else begin
        if (wait_cnt > 0) hold_viol++;
        wait_cnt = 0;
      end
    end
  end

  task automatic xact(input logic wr, input logic [6:0] addr, input logic [15:0] wd,
                      output logic got_hit, output logic [15:0] got_q,
                      output int lat, output int nmem, output logic v_after);
    int guard;
    int base;
    guard = 0;
    while (!cpu_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    base      = log_n;
    cpu_req   = 1'b1;
    cpu_wren  = wr;
    cpu_addr  = addr;
    cpu_wdata = wd;
    @(negedge clk);
    cpu_req = 1'b0;
    lat = 1;
    while (!cpu_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    check("cpu_valid_seen", {31'b0, cpu_valid}, 32'd1);
    got_hit = hit;
    got_q   = q;
    nmem    = log_n - base;
    @(negedge clk);
    v_after = cpu_valid;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic        h, va;
    logic [15:0] d;
    int          lat, nm, b, g;

    for (int i = 0; i < 128; i++) mem_model[i] = 16'h1000 + 16'(i);
    mem_model[7'h14] = 16'hAAAA;
    mem_model[7'h15] = 16'hBBBB;

    reset = 1'b1; cpu_req = 1'b0; cpu_wren = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    repeat (3) @(negedge clk);
    check("rst_ctrl", {28'b0, cpu_ready, cpu_valid, hit, mem_req}, 32'b1000);
    check("rst_we_q", {15'b0, mem_we, q}, 32'h0);
    check("rst_mem_bus", {9'b0, mem_addr, mem_wdata}, 32'h0);
    reset = 1'b0;
    @(negedge clk);

    // Cold read miss: two beats, critical word from beat 0
    b = log_n;
    xact(1'b0, 7'h14, 16'h0, h, d, lat, nm, va);
    check("t1_hit", {31'b0, h}, 32'd0);
    check("t1_q", {16'b0, d}, 32'hAAAA);
    check("t1_beats", nm, 2);
    check("t1_beat0", {24'b0, log_we[b % 64], log_addr[b % 64]}, 32'h14);
    check("t1_beat1", {24'b0, log_we[(b+1) % 64], log_addr[(b+1) % 64]}, 32'h15);
    check("t1_one_cycle", {31'b0, va}, 32'd0);

    xact(1'b0, 7'h15, 16'h0, h, d, lat, nm, va);
    check("t2_hit", {31'b0, h}, 32'd1);
    check("t2_q", {16'b0, d}, 32'hBBBB);
    check("t2_latency", lat, 2);
    check("t2_no_mem", nm, 0);

    // Write hit: old word returned, store forwarded
    b = log_n;
    xact(1'b1, 7'h15, 16'h1234, h, d, lat, nm, va);
    check("t3w_hit", {31'b0, h}, 32'd1);
    check("t3w_q_old", {16'b0, d}, 32'hBBBB);
    check("t3w_stores", nm, 1);
    check("t3w_store", {8'b0, log_we[b % 64], log_addr[b % 64], log_wd[b % 64]}, {8'b0, 1'b1, 7'h15, 16'h1234});
    xact(1'b0, 7'h15, 16'h0, h, d, lat, nm, va);
    check("t3r_hit", {31'b0, h}, 32'd1);
    check("t3r_q", {16'b0, d}, 32'h1234);
    check("t3r_no_mem", nm, 0);

    // LRU in set 0: A=0x14, B=0x20, C=0x40
    xact(1'b0, 7'h20, 16'h0, h, d, lat, nm, va);
    check("t4_b_miss", {31'b0, h}, 32'd0);
    check("t4_b_q", {16'b0, d}, 32'h1020);
    check("t4_b_beats", nm, 2);
    xact(1'b0, 7'h14, 16'h0, h, d, lat, nm, va);
    check("t4_a_hit", {31'b0, h}, 32'd1);
    xact(1'b0, 7'h40, 16'h0, h, d, lat, nm, va);
    check("t4_c_miss", {31'b0, h}, 32'd0);
    check("t4_c_q", {16'b0, d}, 32'h1040);
    xact(1'b0, 7'h14, 16'h0, h, d, lat, nm, va);
    check("t4_a_kept", {31'b0, h}, 32'd1);
    check("t4_a_q", {16'b0, d}, 32'hAAAA);
    xact(1'b0, 7'h20, 16'h0, h, d, lat, nm, va);
    check("t4_b_evicted", {31'b0, h}, 32'd0);
    check("t4_b_refill", nm, 2);

    // Write miss: no allocate
    b = log_n;
    xact(1'b1, 7'h7C, 16'hABCD, h, d, lat, nm, va);
    check("t5w_hit", {31'b0, h}, 32'd0);
    check("t5w_q", {16'b0, d}, 32'h0);
    check("t5w_store", {8'b0, log_we[b % 64], log_addr[b % 64], log_wd[b % 64]}, {8'b0, 1'b1, 7'h7C, 16'hABCD});
    xact(1'b0, 7'h7C, 16'h0, h, d, lat, nm, va);
    check("t5r_miss", {31'b0, h}, 32'd0);
    check("t5r_beats", nm, 2);
    check("t5r_q", {16'b0, d}, 32'hABCD);

    check("req_gap", gap_viol, 0);
    check("req_hold", hold_viol, 0);

    // Reset during the second refill beat
    g = 0;
    while (!cpu_ready && g < 100) begin @(negedge clk); g++; end
    cpu_req = 1'b1; cpu_wren = 1'b0; cpu_addr = 7'h03;
    @(negedge clk);
    cpu_req = 1'b0;
    g = 0;
    while (!(mem_req && mem_addr == 7'h03) && g < 200) begin @(negedge clk); g++; end
    check("t6_beat1_seen", {24'b0, mem_req, mem_addr}, {24'b0, 1'b1, 7'h03});
    reset = 1'b1;
    #1;
    check("t6_req_drop", {31'b0, mem_req}, 32'd0);
    check("t6_ready", {31'b0, cpu_ready}, 32'd1);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    xact(1'b0, 7'h03, 16'h0, h, d, lat, nm, va);
    check("t6_miss_again", {31'b0, h}, 32'd0);
    check("t6_beats", nm, 2);
    check("t6_q", {16'b0, d}, 32'h1003);
`ifdef CACHE_STATS_EN
    check("stat_hits", stat_hits, 32'd0);
    check("stat_misses", stat_misses, 32'd1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
